dwt_tap_accum: RTL
==================

DWT_TAP_ACCUM -- requirements
Module: dwt_tap_accum

Interface
REQ-001 Parameter TAPS, default 9, SHALL set the product count per output coefficient (range 2..15).
REQ-002 Parameter PROD_W, default 20, SHALL set the unsigned product width from the upstream multiplier.
REQ-003 Parameter ACC_W, default 25, SHALL set the signed accumulator width; it SHALL satisfy ACC_W >= PROD_W + ceil(log2(TAPS)) + 1.
REQ-004 Parameter SHIFT, default 8, SHALL set the fixed-point right shift applied to the sum (range 1..ACC_W-2).
REQ-005 Parameter OUT_W, default 12, SHALL set the signed output coefficient width.
REQ-006 ap_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 ap_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-008 prod_tdata  in  PROD_W  SHALL carry the unsigned product.
REQ-009 prod_neg  in  1  SHALL select subtract (1) or add (0) for the product; it is qualified by prod_tvalid.
REQ-010 prod_tvalid  in  1 / prod_tready  out  1  SHALL form the input handshake; a transfer occurs when both are high.
REQ-011 coef_tdata  out  OUT_W  SHALL carry the signed coefficient.
REQ-012 coef_tvalid  out  1 / coef_tready  in  1  SHALL form the output handshake.
REQ-013 sat_flag  out  1  SHALL pulse high for one cycle with a saturated coefficient.

Function
REQ-014 FSM states SHALL be ACCUM and HOLD; tap_cnt counts 0..TAPS-1.
REQ-015 In ACCUM, prod_tready SHALL be 1.
REQ-016 Each input transfer SHALL update acc as follows: tap_cnt==0 gives acc = ±product; otherwise acc = acc ± product (sign extended to ACC_W).
REQ-017 On the transfer with tap_cnt==TAPS-1, the block SHALL register the rounded result into coef_tdata, clear tap_cnt, and enter HOLD.
REQ-018 Rounding SHALL be computed as (acc_final + 2^(SHIFT-1)) >>> SHIFT, an arithmetic shift computed at ACC_W+1 bits.
REQ-019 Latency SHALL be one cycle: coef_tvalid rises in the cycle after the last tap transfer.
REQ-020 In HOLD, coef_tvalid SHALL be 1 and coef_tdata SHALL be stable until coef_tready is 1.
REQ-021 In HOLD, prod_tready SHALL equal coef_tready.
REQ-022 A simultaneous output acceptance and input transfer in HOLD SHALL start the next coefficient with tap_cnt==0 semantics and return to ACCUM.
REQ-023 In HOLD with coef_tready==1 and no input transfer, the block SHALL return to ACCUM with tap_cnt 0.
REQ-024 When TAPS==2, back-to-back operation SHALL sustain one coefficient per 2 cycles with coef_tready held high.
REQ-025 prod_neg SHALL be sampled only on transfer; its value when prod_tvalid is 0 SHALL have no effect.

Reset
REQ-026 Asserting ap_rst_n low SHALL immediately force state ACCUM, tap_cnt 0, acc 0, coef_tdata 0, coef_tvalid 0, and sat_flag 0.
REQ-027 Reset mid-accumulation or in HOLD SHALL discard the partial sum or pending coefficient; no output SHALL follow release.
REQ-028 prod_tready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 When DWT_TAP_SAT_EN is defined, the rounded result SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and sat_flag SHALL assert with a clamped coefficient.
REQ-030 When DWT_TAP_SAT_EN is not defined, coef_tdata SHALL be the low OUT_W bits of the rounded result and sat_flag SHALL be tied 0.

Structure
REQ-031 Package dwt_accel_pkg SHALL hold the default width constants (PROD_W, ACC_W, OUT_W, SHIFT) and the FSM state enum.
REQ-032 Rounding and saturation SHALL be in one combinational sub-module, dwt_tap_round_sat, instantiated once.

Verification (TAPS=9, SHIFT=8, OUT_W=12)
REQ-033 Nine add transfers of 256 -> coef_tdata=9 one cycle after the 9th transfer; sat_flag=0.
REQ-034 Nine subtract transfers of 256 -> coef_tdata=-9 (0xFF7).
REQ-035 Nine add transfers of 0xFFFFF -> coef_tdata=2047 and sat_flag=1 with DWT_TAP_SAT_EN; coef_tdata=0x000 and sat_flag=0 without it.
REQ-036 coef_tready held 0 for 5 cycles in HOLD -> coef_tdata stable and prod_tready=0 throughout; on the release cycle a concurrent transfer of 512 begins the next sum.
REQ-037 ap_rst_n pulsed low after 4 transfers, then 9 add transfers of 256 -> exactly one coefficient, value 9.
REQ-038 Random prod_tvalid/coef_tready gaps over 1000 coefficients -> scoreboard match against a reference model; no lost or duplicated outputs.

Source files
------------

// File: rtl/dwt_accel_pkg.sv
// ============================================================================
// Module  : dwt_accel_pkg
// Brief   : Default widths and FSM state type shared by the DWT tap accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dwt_accel_pkg;

  localparam int C_TAPS      = 9;
  localparam int C_PROD_W    = 20;
  localparam int C_ACC_W     = 25;
  localparam int C_SHIFT     = 8;
  localparam int C_OUT_W     = 12;
  // Wide enough for the largest supported tap count (15).
  localparam int C_TAP_CNT_W = 4;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } dwt_state_e;

endpackage

`default_nettype wire

// File: rtl/dwt_tap_round_sat.sv
// ============================================================================
// Module  : dwt_tap_round_sat
// Brief   : Round-half-up arithmetic right shift of the final sum, optionally
//           clamped to the signed output range when DWT_TAP_SAT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dwt_tap_round_sat
  import dwt_accel_pkg::*;
#(
  parameter int ACC_W = C_ACC_W,
  parameter int SHIFT = C_SHIFT,
  parameter int OUT_W = C_OUT_W
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] coef_o,
  output logic             sat_o
);

  localparam logic [ACC_W:0] C_HALF = (ACC_W+1)'(1) << (SHIFT-1);

  logic        [ACC_W:0] w_biased;
  logic signed [ACC_W:0] w_rounded;

  // One guard bit keeps the rounding bias from overflowing the sum.
  assign w_biased  = {acc_i[ACC_W-1], acc_i} + C_HALF;
  assign w_rounded = $signed(w_biased) >>> SHIFT;

`ifdef DWT_TAP_SAT_EN
  localparam logic signed [ACC_W:0] C_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] C_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    coef_o = w_rounded[OUT_W-1:0];
    sat_o  = 1'b0;
    if (w_rounded > C_MAX) begin
      coef_o = C_MAX[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (w_rounded < C_MIN) begin
      coef_o = C_MIN[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end
`else
  logic w_unused_hi;

  assign coef_o      = w_rounded[OUT_W-1:0];
  assign sat_o       = 1'b0;
  assign w_unused_hi = ^w_rounded[ACC_W:OUT_W];
`endif

endmodule

`default_nettype wire

// File: rtl/dwt_tap_accum.sv
// ============================================================================
// Module  : dwt_tap_accum
// Brief   : Signed multiply-accumulate over TAPS products per DWT coefficient,
//           with rounded output held under a valid/ready handshake.
//           Optional saturation: define DWT_TAP_SAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dwt_tap_accum
  import dwt_accel_pkg::*;
#(
  parameter int TAPS   = C_TAPS,
  parameter int PROD_W = C_PROD_W,
  parameter int ACC_W  = C_ACC_W,
  parameter int SHIFT  = C_SHIFT,
  parameter int OUT_W  = C_OUT_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PROD_W-1:0] prod_tdata,
  input  logic              prod_neg,
  input  logic              prod_tvalid,
  output logic              prod_tready,
  output logic [OUT_W-1:0]  coef_tdata,
  output logic              coef_tvalid,
  input  logic              coef_tready,
  output logic              sat_flag
);

  localparam logic [C_TAP_CNT_W-1:0] C_LAST_TAP = C_TAP_CNT_W'(TAPS-1);

  dwt_state_e             state_q, state_d;
  logic [C_TAP_CNT_W-1:0] tap_cnt_q, tap_cnt_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [OUT_W-1:0]       coef_q, coef_d;
  logic                   sat_q, sat_d;

  logic                   w_xfer;
  logic                   w_last;
  logic [ACC_W-1:0]       w_prod_ext;
  logic [ACC_W-1:0]       w_acc_base;
  logic [ACC_W-1:0]       w_acc_sum;
  logic [OUT_W-1:0]       w_round_coef;
  logic                   w_round_sat;

  assign w_xfer     = prod_tvalid & prod_tready;
  assign w_last     = (tap_cnt_q == C_LAST_TAP);
  assign w_prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod_tdata};
  // The first tap of a coefficient discards the previous sum instead of clearing it separately.
  assign w_acc_base = (tap_cnt_q == '0) ? '0 : acc_q;
  assign w_acc_sum  = prod_neg ? (w_acc_base - w_prod_ext) : (w_acc_base + w_prod_ext);

  dwt_tap_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .acc_i  (w_acc_sum),
    .coef_o (w_round_coef),
    .sat_o  (w_round_sat)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM: if (w_xfer && w_last) state_d = ST_HOLD;
      ST_HOLD:  if (coef_tready)      state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    prod_tready = 1'b1;
    coef_tvalid = 1'b0;
    if (state_q == ST_HOLD) begin
      // A new coefficient may only start once the held one is taken.
      prod_tready = coef_tready;
      coef_tvalid = 1'b1;
    end
  end

  always_comb begin
    tap_cnt_d = tap_cnt_q;
    acc_d     = acc_q;
    coef_d    = coef_q;
    sat_d     = 1'b0;
    if (w_xfer) begin
      acc_d = w_acc_sum;
      if (w_last) begin
        tap_cnt_d = '0;
        coef_d    = w_round_coef;
        sat_d     = w_round_sat;
      end else begin
        tap_cnt_d = tap_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tap_cnt_q <= '0;
      acc_q     <= '0;
      coef_q    <= '0;
      sat_q     <= 1'b0;
    end else begin
      tap_cnt_q <= tap_cnt_d;
      acc_q     <= acc_d;
      coef_q    <= coef_d;
      sat_q     <= sat_d;
    end
  end

  assign coef_tdata = coef_q;
  assign sat_flag   = sat_q;

endmodule

`default_nettype wire
